// File: rtl/dmac_wrr_arbiter.sv
//-----------------------------------------------------------------------------
// dmac_wrr_arbiter
//
// N-master to 1 weighted round-robin arbiter for the DMAC data path.
// Each grant gives the winning master a quantum of beats (its programmed
// weight, 0 counting as 1). A packet delimited by src_last_i is never split:
// once a packet is open the owner keeps the port until its last beat, even
// if the quantum ran out. Accepted beats go through one registered output
// stage tagged with the index of the master that sourced them.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   weight_i     : per-master quantum in beats (sampled at each new grant)
//   src_valid_i  : per-master beat available
//   src_ready_o  : per-master beat accepted this cycle (combinational)
//   src_data_i   : per-master beat data
//   src_last_i   : per-master final-beat-of-packet flag
//   dst_valid_o  : output beat valid (registered)
//   dst_ready_i  : downstream accepts the output beat
//   dst_data_o   : output beat data (registered)
//   dst_last_o   : output beat last flag (registered)
//   dst_id_o     : index of the master that sourced the beat (registered)
//-----------------------------------------------------------------------------
module dmac_wrr_arbiter #(
    parameter  int N_MASTER  = 4,
    parameter  int DATA_SIZE = 32,
    parameter  int WEIGHT_W  = 4,
    localparam int ID_W      = $clog2(N_MASTER)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WEIGHT_W-1:0]  weight_i    [N_MASTER],
    input  logic [N_MASTER-1:0]  src_valid_i,
    output logic [N_MASTER-1:0]  src_ready_o,
    input  logic [DATA_SIZE-1:0] src_data_i  [N_MASTER],
    input  logic [N_MASTER-1:0]  src_last_i,
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [DATA_SIZE-1:0] dst_data_o,
    output logic                 dst_last_o,
    output logic [ID_W-1:0]      dst_id_o
);

    localparam logic [WEIGHT_W-1:0] CREDIT_ZERO = {WEIGHT_W{1'b0}};
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE  = WEIGHT_W'(1);

    // Index addition modulo N_MASTER; off is always below N_MASTER, so a
    // single conditional subtract is enough (also correct for non-power-of-2 N).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int              off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_MASTER) begin
            sum = sum - N_MASTER;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // Arbitration state
    logic [ID_W-1:0]      owner_r;
    logic [WEIGHT_W-1:0]  credit_r;
    logic                 locked_r;
    logic [ID_W-1:0]      ptr_r;

    // Output stage
    logic                 dst_valid_r;
    logic [DATA_SIZE-1:0] dst_data_r;
    logic                 dst_last_r;
    logic [ID_W-1:0]      dst_id_r;

    // Combinational decode
    logic                 load_en_s;
    logic                 owner_valid_s;
    logic                 hold_s;
    logic                 forfeit_s;
    logic [ID_W-1:0]      start_s;
    logic                 search_hit_s;
    logic [ID_W-1:0]      search_id_s;
    logic                 grant_s;
    logic [ID_W-1:0]      grant_id_s;
    logic [WEIGHT_W-1:0]  grant_weight_s;
    logic [WEIGHT_W-1:0]  credit_after_s;
    logic [ID_W-1:0]      ptr_after_forfeit_s;
    logic                 grant_last_s;

    // Next-state values
    logic [ID_W-1:0]      owner_nxt_s;
    logic [WEIGHT_W-1:0]  credit_nxt_s;
    logic                 locked_nxt_s;
    logic [ID_W-1:0]      ptr_nxt_s;
    logic                 dst_valid_nxt_s;
    logic [DATA_SIZE-1:0] dst_data_nxt_s;
    logic                 dst_last_nxt_s;
    logic [ID_W-1:0]      dst_id_nxt_s;

    // The output stage can take a new beat when empty or being drained.
    assign load_en_s     = !dst_valid_r || dst_ready_i;
    assign owner_valid_s = src_valid_i[owner_r];
    // The owner keeps the port while its packet is open, or while it still
    // has quantum left and keeps offering beats.
    assign hold_s        = locked_r || ((credit_r != CREDIT_ZERO) && owner_valid_s);
    // Owner went idle between packets with quantum left: it gives the rest
    // up and the search starts just past it in this same cycle.
    assign forfeit_s     = !hold_s && (credit_r != CREDIT_ZERO);
    assign ptr_after_forfeit_s = forfeit_s ? wrap_add(owner_r, 1) : ptr_r;
    assign start_s       = ptr_after_forfeit_s;

    // Round-robin search: first valid master at or after start_s (cyclic).
    always_comb begin
        search_hit_s = 1'b0;
        search_id_s  = {ID_W{1'b0}};
        for (int k = 0; k < N_MASTER; k++) begin
            search_id_s  = (!search_hit_s && src_valid_i[wrap_add(start_s, k)])
                           ? wrap_add(start_s, k) : search_id_s;
            search_hit_s = search_hit_s || src_valid_i[wrap_add(start_s, k)];
        end
    end

    // Winner selection; nothing is granted in reset or while the output stalls.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = owner_r;
        if (rst || !load_en_s) begin
            grant_s    = 1'b0;
            grant_id_s = owner_r;
        end else if (hold_s) begin
            // While locked, a missing owner beat blocks everyone else.
            grant_s    = owner_valid_s;
            grant_id_s = owner_r;
        end else begin
            grant_s    = search_hit_s;
            grant_id_s = search_id_s;
        end
    end

    // One-hot ready toward the winning master.
    always_comb begin
        src_ready_o = {N_MASTER{1'b0}};
        for (int i = 0; i < N_MASTER; i++) begin
            src_ready_o[i] = grant_s && (grant_id_s == ID_W'(i));
        end
    end

    assign grant_weight_s = weight_i[grant_id_s];
    assign grant_last_s   = src_last_i[grant_id_s];

    // Remaining quantum after this beat: a held grant burns one beat
    // (saturating, since a locked packet may outrun its quantum); a new
    // grant reloads from the weight, with weight 0 behaving as 1.
    always_comb begin
        credit_after_s = CREDIT_ZERO;
        if (hold_s) begin
            credit_after_s = (credit_r == CREDIT_ZERO) ? CREDIT_ZERO : (credit_r - CREDIT_ONE);
        end else begin
            credit_after_s = (grant_weight_s == CREDIT_ZERO) ? CREDIT_ZERO
                                                             : (grant_weight_s - CREDIT_ONE);
        end
    end

    // Next-state for arbitration state and output stage.
    always_comb begin
        owner_nxt_s     = owner_r;
        credit_nxt_s    = credit_r;
        locked_nxt_s    = locked_r;
        ptr_nxt_s       = ptr_r;
        dst_valid_nxt_s = dst_valid_r;
        dst_data_nxt_s  = dst_data_r;
        dst_last_nxt_s  = dst_last_r;
        dst_id_nxt_s    = dst_id_r;
        if (load_en_s) begin
            if (grant_s) begin
                dst_valid_nxt_s = 1'b1;
                dst_data_nxt_s  = src_data_i[grant_id_s];
                dst_last_nxt_s  = grant_last_s;
                dst_id_nxt_s    = grant_id_s;
                owner_nxt_s     = grant_id_s;
                locked_nxt_s    = !grant_last_s;
                credit_nxt_s    = credit_after_s;
                // Quantum spent on a packet boundary: move on past this master.
                ptr_nxt_s       = ((credit_after_s == CREDIT_ZERO) && grant_last_s)
                                  ? wrap_add(grant_id_s, 1) : ptr_after_forfeit_s;
            end else begin
                // Drained with nothing to replace it; payload fields hold.
                dst_valid_nxt_s = 1'b0;
                credit_nxt_s    = forfeit_s ? CREDIT_ZERO : credit_r;
                ptr_nxt_s       = ptr_after_forfeit_s;
            end
        end else begin
            // Output stalled: everything frozen.
            dst_valid_nxt_s = dst_valid_r;
            credit_nxt_s    = credit_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r     <= {ID_W{1'b0}};
            credit_r    <= CREDIT_ZERO;
            locked_r    <= 1'b0;
            ptr_r       <= {ID_W{1'b0}};
            dst_valid_r <= 1'b0;
            dst_data_r  <= {DATA_SIZE{1'b0}};
            dst_last_r  <= 1'b0;
            dst_id_r    <= {ID_W{1'b0}};
        end else begin
            owner_r     <= owner_nxt_s;
            credit_r    <= credit_nxt_s;
            locked_r    <= locked_nxt_s;
            ptr_r       <= ptr_nxt_s;
            dst_valid_r <= dst_valid_nxt_s;
            dst_data_r  <= dst_data_nxt_s;
            dst_last_r  <= dst_last_nxt_s;
            dst_id_r    <= dst_id_nxt_s;
        end
    end

    assign dst_valid_o = dst_valid_r;
    assign dst_data_o  = dst_data_r;
    assign dst_last_o  = dst_last_r;
    assign dst_id_o    = dst_id_r;

endmodule

// File: doc/dmac_wrr_arbiter.md
# dmac_wrr_arbiter

Parametrised N-master to 1 weighted round-robin arbiter for the DMAC data path, succeeding the fixed 4-master arbiter. Grants a per-master quantum of beats (runtime-programmable weight), never splits a packet delimited by `src_last_i`, and forwards data through one registered output stage tagged with the winning master's index. Sits between the per-channel DMAC engines and the shared AXI write/read data port.

## Interface
- `N_MASTER`, 4, number of requesting masters (2..16)
- `DATA_SIZE`, 32, data width in bits
- `WEIGHT_W`, 4, width of each per-master weight
- `ID_W`, `$clog2(N_MASTER)`, width of master index (localparam)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `weight_i[N_MASTER]`  in  WEIGHT_W  beats per grant quantum; 0 treated as 1
- `src_valid_i[N_MASTER]`  in  1  master has a beat
- `src_ready_o[N_MASTER]`  out  1  beat accepted this cycle (combinational)
- `src_data_i[N_MASTER]`  in  DATA_SIZE  beat data
- `src_last_i[N_MASTER]`  in  1  beat is final of its packet
- `dst_valid_o`  out  1  output beat valid (registered)
- `dst_ready_i`  in  1  downstream accepts
- `dst_data_o`  out  DATA_SIZE  output data (registered)
- `dst_last_o`  out  1  last flag of output beat (registered)
- `dst_id_o`  out  ID_W  index of master that sourced the beat (registered)

## Operation
- State: `owner` (ID_W), `credit` (WEIGHT_W), `locked` (1, packet open), `ptr` (ID_W, next search start).
- `load_en = !dst_valid_o || dst_ready_i`.
- Hold condition: `hold = locked || (credit != 0 && src_valid_i[owner])`.
- Selection (only when `load_en`):
  - `hold`: winner = `owner` if `src_valid_i[owner]`, else no grant (other masters blocked while `locked`).
  - `!hold`: winner = first `i` with `src_valid_i[i]`, searching `ptr, ptr+1, …, N_MASTER-1, 0, …` (mod N_MASTER).
- Exactly one `src_ready_o[winner]` = 1 when a winner exists; all 0 otherwise.
- On accepted beat from `g`:
  - Output register loads `src_data_i[g]`, `src_last_i[g]`, `g`; `dst_valid_o` <= 1.
  - New grant (`!hold` path): `credit <= max(weight_i[g],1) - 1`; `weight_i` sampled only here.
  - Held grant: `credit <= credit - 1`, saturating at 0.
  - `owner <= g`; `locked <= !src_last_i[g]`.
  - If resulting credit = 0 and `src_last_i[g]`: `ptr <= (g+1) mod N_MASTER`.
- Owner drops valid with credit left and packet closed: `hold` falls, the owner forfeits its remaining quantum, `ptr <= (owner+1) mod N_MASTER`, and search runs from the new `ptr` in the same cycle (owner index excluded via pointer start only).
- Credit exhausted mid-packet: grant retained until the `last` beat, then released.
- No winner and `dst_ready_i` while `dst_valid_o`: `dst_valid_o` <= 0; data/id/last hold their values.
- `dst_valid_o && !dst_ready_i`: output stage and all state frozen; no `src_ready_o` asserted.

## Timing
- Reset (`rst` high at edge): `dst_valid_o`=0, `dst_data_o`=0, `dst_last_o`=0, `dst_id_o`=0, `owner`=0, `credit`=0, `locked`=0, `ptr`=0. `src_ready_o` forced 0 while `rst`=1. Reset mid-packet discards open lock and any held output beat.
- Latency: source beat accepted in cycle T appears on `dst_*` from T+1.
- Throughput: one beat per cycle while `dst_ready_i`=1 (no bubbles on master switch).
- `src_ready_o` depends combinationally on `dst_ready_i`, `src_valid_i`, registered state; no combinational path from `src_data_i` to any output.
- Source handshake: transfer when `src_valid_i[i] && src_ready_o[i]`; masters hold data/last stable until accepted.
- `weight_i` changes take effect at the next new grant of that master.

## Test plan
- N=4, weights all 1, all masters valid, single-beat packets, `dst_ready_i`=1 -> `dst_id_o` sequence 0,1,2,3,0,… one per cycle from cycle 1 after first accept.
- Weights {3,1,2,1}, all valid continuously, single-beat packets -> `dst_id_o` 0,0,0,1,2,2,3,0,0,0,…
- Weight 1 on all, master 1 sends 5-beat packet (last on beat 5) while others valid -> five consecutive `dst_id_o`=1 beats, then 2; master 1 dropping valid at beat 3 -> `dst_valid_o` bubble, no beat from 0/2/3 until master 1 resumes and sends last.
- Master 2 alone with weight 4, goes invalid after 2 beats, master 3 valid -> next beat `dst_id_o`=3, no idle cycle; `ptr` = 3.
- `dst_ready_i` held 0 for 3 cycles with `dst_valid_o`=1 -> `dst_data_o`/`dst_id_o` stable, all `src_ready_o`=0, credit unchanged; resumes in order after release.
- Assert `rst` during open packet from master 0 -> next cycle `dst_valid_o`=0, `locked`=0; after release, master 3 alone valid is granted immediately (`dst_id_o`=3).
